// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions for the Booth multiplier and the signed divider.
// Holds the operand width, the divider FSM encoding and the iteration-count width.
package arith_pkg;

  localparam int N     = 7;
  localparam int DVD_W = 2 * N;
  localparam int CNT_W = $clog2(DVD_W);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  function automatic logic is_busy_state(input div_state_e st);
    return (st == ST_ABS) || (st == ST_DIV) || (st == ST_FIX);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// Used for operand magnitudes and for re-applying signs to the results.
module twos_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // conditional negate
  always_comb begin
    if (neg) begin
      res = ~val + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential restoring signed divider: 2N-bit dividend / N-bit divisor, N taken from arith_pkg.
// Define DIV_OVF_CHECK_EN to compute ovf; otherwise ovf is tied low.
module seq_signed_divider
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [N-1:0]     divisor,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero,
  output logic             ovf
);

`ifdef DIV_OVF_CHECK_EN
  localparam int QW = DVD_W;
  localparam logic [QW-1:0] Q_POS_MAX = QW'((2 ** (N - 1)) - 1);
  localparam logic [QW-1:0] Q_NEG_MAX = QW'(2 ** (N - 1));
`else
  localparam int QW = N;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

  div_state_e state_r, state_nxt_s;

  logic [DVD_W-1:0] dvd_r;
  logic [N-1:0]     dvs_r;
  logic             sign_dvd_r;
  logic             sign_dvs_r;
  logic [DVD_W-1:0] prem_r;
  logic [QW-1:0]    quo_r;
  logic [CNT_W-1:0] cnt_r;

  logic [DVD_W-1:0] mag_dvd_s;
  logic [N-1:0]     mag_dvs_s;
  logic [DVD_W-1:0] shifted_s;
  logic [N+1:0]     trial_s;
  logic             qbit_s;
  logic [DVD_W-1:0] prem_nxt_s;
  logic             q_neg_s;
  logic [N-1:0]     q_signed_s;
  logic [N-1:0]     r_signed_s;
  logic             ovf_calc_s;

  logic [N-1:0] quotient_r, quotient_nxt_s;
  logic [N-1:0] remainder_r, remainder_nxt_s;
  logic         done_r, done_nxt_s;
  logic         busy_r, busy_nxt_s;
  logic         div_zero_r, div_zero_nxt_s;
  logic         ovf_r, ovf_nxt_s;

  assign q_neg_s = sign_dvd_r ^ sign_dvs_r;

  twos_abs #(.W(DVD_W)) u_abs_dvd (.val(dvd_r), .neg(sign_dvd_r), .res(mag_dvd_s));
  twos_abs #(.W(N))     u_abs_dvs (.val(dvs_r), .neg(sign_dvs_r), .res(mag_dvs_s));
  twos_abs #(.W(N))     u_fix_quo (.val(quo_r[N-1:0]),  .neg(q_neg_s),    .res(q_signed_s));
  twos_abs #(.W(N))     u_fix_rem (.val(prem_r[N-1:0]), .neg(sign_dvd_r), .res(r_signed_s));

  // one restoring step; upper partial-remainder bits stay zero, a set bit would force a successful subtract
  always_comb begin
    shifted_s = {prem_r[DVD_W-2:0], dvd_r[DVD_W-1]};
    trial_s   = {1'b0, shifted_s[N:0]} - {2'b00, dvs_r};
    qbit_s    = ~trial_s[N+1] | (|prem_r[DVD_W-1:N]);
    if (qbit_s) begin
      prem_nxt_s = {{(N-1){1'b0}}, trial_s[N:0]};
    end else begin
      prem_nxt_s = shifted_s;
    end
  end

`ifdef DIV_OVF_CHECK_EN
  // quotient range check against the signed N-bit limits
  always_comb begin
    if (q_neg_s) begin
      ovf_calc_s = (quo_r > Q_NEG_MAX);
    end else begin
      ovf_calc_s = (quo_r > Q_POS_MAX);
    end
  end
`else
  assign ovf_calc_s = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ABS;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ABS: begin
        if (dvs_r == {N{1'b0}}) state_nxt_s = ST_DONE;
        else                    state_nxt_s = ST_DIV;
      end
      ST_DIV: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_FIX;
        else                   state_nxt_s = ST_DIV;
      end
      ST_FIX:  state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (start) state_nxt_s = ST_ABS;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // operand latch, magnitude formation and the shift/subtract datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r      <= {DVD_W{1'b0}};
      dvs_r      <= {N{1'b0}};
      sign_dvd_r <= 1'b0;
      sign_dvs_r <= 1'b0;
      prem_r     <= {DVD_W{1'b0}};
      quo_r      <= {QW{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_r      <= dividend;
            dvs_r      <= divisor;
            sign_dvd_r <= dividend[DVD_W-1];
            sign_dvs_r <= divisor[N-1];
          end
        end
        ST_ABS: begin
          dvd_r  <= mag_dvd_s;
          dvs_r  <= mag_dvs_s;
          prem_r <= {DVD_W{1'b0}};
          quo_r  <= {QW{1'b0}};
          cnt_r  <= {CNT_W{1'b0}};
        end
        ST_DIV: begin
          dvd_r  <= {dvd_r[DVD_W-2:0], 1'b0};
          prem_r <= prem_nxt_s;
          quo_r  <= {quo_r[QW-2:0], qbit_s};
          cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // next values of the registered outputs
  always_comb begin
    quotient_nxt_s  = quotient_r;
    remainder_nxt_s = remainder_r;
    div_zero_nxt_s  = div_zero_r;
    ovf_nxt_s       = ovf_r;
    done_nxt_s      = 1'b0;
    busy_nxt_s      = is_busy_state(state_nxt_s);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          div_zero_nxt_s = 1'b0;
          ovf_nxt_s      = 1'b0;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ST_ABS: begin
        if (dvs_r == {N{1'b0}}) begin
          div_zero_nxt_s  = 1'b1;
          quotient_nxt_s  = {N{1'b0}};
          remainder_nxt_s = {N{1'b0}};
        end else begin
          div_zero_nxt_s = 1'b0;
        end
      end
      ST_FIX: begin
        quotient_nxt_s  = q_signed_s;
        remainder_nxt_s = r_signed_s;
        ovf_nxt_s       = ovf_calc_s;
      end
      ST_DONE: begin
        if (start) begin
          div_zero_nxt_s = 1'b0;
          ovf_nxt_s      = 1'b0;
          done_nxt_s     = 1'b0;
        end else begin
          done_nxt_s = 1'b1;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r  <= {N{1'b0}};
      remainder_r <= {N{1'b0}};
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      quotient_r  <= quotient_nxt_s;
      remainder_r <= remainder_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
      div_zero_r  <= div_zero_nxt_s;
      ovf_r       <= ovf_nxt_s;
    end
  end

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign div_zero  = div_zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed plus random operands against
// an integer-arithmetic reference model.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] dividend;
  logic [6:0]  divisor;
  logic [6:0]  quotient;
  logic [6:0]  remainder;
  logic        done;
  logic        busy;
  logic        div_zero;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  seq_signed_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
    .div_zero(div_zero), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference: plain signed integer division, truncating toward zero
  task automatic model(input logic [13:0] a, input logic [6:0] b,
                       output logic [6:0] eq, output logic [6:0] er,
                       output logic edz, output logic eovf, output int elat);
    int sa, sb, q, r;
    logic [31:0] qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      eq = 7'h00; er = 7'h00; edz = 1'b1; eovf = 1'b0; elat = 2;
    end else begin
      q = sa / sb;
      r = sa % sb;
      qv = q; rv = r;
      eq = qv[6:0]; er = rv[6:0]; edz = 1'b0; elat = 17;
`ifdef DIV_OVF_CHECK_EN
      eovf = (q > 63) || (q < -64);
`else
      eovf = 1'b0;
`endif
    end
  endtask

  task automatic run_op(input logic [13:0] a, input logic [6:0] b, input bit pulse);
    logic [6:0] eq, er;
    logic edz, eovf;
    int elat, lat;
    model(a, b, eq, er, edz, eovf, elat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (pulse && lat == 6) begin
        dividend = ~a; divisor = b + 7'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check_val("latency", lat, elat);
    check_val("quotient", {25'd0, quotient}, {25'd0, eq});
    check_val("remainder", {25'd0, remainder}, {25'd0, er});
    check_val("div_zero", {31'd0, div_zero}, {31'd0, edz});
    check_val("ovf", {31'd0, ovf}, {31'd0, eovf});
    check_val("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_quotient"}, {25'd0, quotient}, 32'd0);
    check_val({tag, "_remainder"}, {25'd0, remainder}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
    check_val({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  logic [13:0] dir_dvd [10] = '{14'h3F7E, 14'h005A, 14'h0064, 14'h3F9C, 14'h0064,
                                14'h1000, 14'h3FC0, 14'h2000, 14'h0064, 14'h3F9C};
  logic [6:0]  dir_dvs [10] = '{7'h0D, 7'h0A, 7'h07, 7'h07, 7'h00,
                                7'h01, 7'h7F, 7'h7F, 7'h40, 7'h79};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] ra;
    logic [6:0]  rb;
    rst = 1'b1; start = 1'b0; dividend = 14'h0000; divisor = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(dir_dvd[i], dir_dvs[i], 1'b0);

    // start pulsed mid-DIV must be ignored
    run_op(14'h0064, 7'h07, 1'b1);

    // reset in the middle of DIV aborts and clears outputs
    @(negedge clk);
    dividend = 14'h3F7E; divisor = 7'h0D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("mid_div_reset");
    @(negedge clk);
    rst = 1'b0;
    run_op(14'h3F9C, 7'h07, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 14'($urandom);
      rb = 7'($urandom);
      if ((i % 8) == 3) rb = 7'h00;
      run_op(ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
